// File: rtl/gtech_or_reduce_pipe_if.sv
// gtech_or_reduce_pipe_if
//   Bundles the data-side signals of gtech_or_reduce_pipe. Clock and reset
//   stay plain ports on the block itself.
//   EN   : input sample valid
//   A    : N vectors of W bits, vector i at A[i*W +: W]
//   CLR  : synchronous clear of ZS/HITS
//   Z    : OR of the most recent valid sample (holds between results)
//   ZV   : one-cycle pulse, high while Z was just updated
//   ANY  : |Z, registered with Z
//   ZS   : sticky OR of results since last CLR/reset
//   HITS : saturating count of nonzero results since last CLR/reset
interface gtech_or_reduce_pipe_if #(
  parameter int unsigned W  = 8,
  parameter int unsigned N  = 3,
  parameter int unsigned CW = 8
);
  logic             EN;
  logic [N*W-1:0]   A;
  logic             CLR;
  logic [W-1:0]     Z;
  logic             ZV;
  logic             ANY;
  logic [W-1:0]     ZS;
  logic [CW-1:0]    HITS;

  modport master (output EN, A, CLR, input Z, ZV, ANY, ZS, HITS);
  modport slave  (input EN, A, CLR, output Z, ZV, ANY, ZS, HITS);
endinterface

// File: rtl/gtech_or_reduce_pipe.sv
// gtech_or_reduce_pipe
//   Pipelined OR-reduction of N W-bit vectors through a registered tree of
//   FANIN-input levels, plus a sticky accumulated OR and a saturating count
//   of nonzero results.
//   CP  : clock, rising edge
//   CD  : asynchronous active-low reset (already synchronised by integrator)
//   bus : gtech_or_reduce_pipe_if.slave (EN, A, CLR in; Z, ZV, ANY, ZS, HITS out)
//   Latency L = max(1, ceil(log_FANIN(N))) cycles from the sampling edge.
module gtech_or_reduce_pipe #(
  parameter int unsigned W     = 8,
  parameter int unsigned N     = 3,
  parameter int unsigned FANIN = 2,
  parameter int unsigned CW    = 8
) (
  input  logic                  CP,
  input  logic                  CD,
  gtech_or_reduce_pipe_if.slave bus
);

  // Number of operands present at tree level k (level 0 = the N inputs).
  function automatic int unsigned lvl_cnt(input int unsigned k);
    int unsigned c;
    c = N;
    for (int unsigned i = 0; i < k; i++) c = (c + FANIN - 1) / FANIN;
    return c;
  endfunction

  function automatic int unsigned num_lvls();
    int unsigned c;
    int unsigned l;
    c = N;
    l = 0;
    while (c > 1) begin
      c = (c + FANIN - 1) / FANIN;
      l++;
    end
    return (l == 0) ? 1 : l;
  endfunction

  localparam int unsigned L = num_lvls();

  logic [W-1:0]  a_vec  [N];
  logic [W-1:0]  opnd   [L][N];      // opnd[k] feeds tree level k+1
  logic [W-1:0]  raw    [1:L][N];    // unregistered OR for each level
  logic [W-1:0]  tree_d [1:L][N];
  logic [W-1:0]  tree_q [1:L][N];
  logic [L:1]    vld_d, vld_q;
  logic          any_d, any_q;
  logic [W-1:0]  zs_d, zs_q;
  logic [CW-1:0] hits_d, hits_q;
  logic [W-1:0]  res;
  logic          res_vld;

  always_comb begin
    for (int unsigned i = 0; i < N; i++) a_vec[i] = bus.A[i*W +: W];

    for (int unsigned j = 0; j < N; j++) opnd[0][j] = a_vec[j];
    for (int unsigned k = 1; k < L; k++)
      for (int unsigned j = 0; j < N; j++) opnd[k][j] = tree_q[k][j];

    // Group j of level k ORs operands j*FANIN .. j*FANIN+FANIN-1 of level k-1;
    // a short last group simply ORs fewer operands.
    for (int unsigned k = 1; k <= L; k++) begin
      for (int unsigned j = 0; j < N; j++) begin
        raw[k][j] = '0;
        if (j < lvl_cnt(k)) begin
          for (int unsigned m = 0; m < FANIN; m++) begin
            if (j * FANIN + m < lvl_cnt(k - 1))
              raw[k][j] = raw[k][j] | opnd[k-1][j*FANIN + m];
          end
        end
      end
    end
  end

  always_comb begin
    vld_d[1] = bus.EN;
    for (int unsigned k = 2; k <= L; k++) vld_d[k] = vld_q[k-1];

    res     = raw[L][0];
    res_vld = vld_d[L];

    // Inner levels load every cycle; the final level is the Z register and
    // only loads alongside a valid result.
    for (int unsigned k = 1; k <= L; k++)
      for (int unsigned j = 0; j < N; j++)
        tree_d[k][j] = (k < L || res_vld) ? raw[k][j] : tree_q[k][j];

    any_d = res_vld ? (|res) : any_q;

    // A CLR coinciding with a result clears and loads in one step.
    if (bus.CLR) begin
      zs_d   = res_vld ? res : '0;
      hits_d = (res_vld && (res != '0)) ? CW'(1) : '0;
    end else begin
      zs_d   = res_vld ? (zs_q | res) : zs_q;
      hits_d = (res_vld && (res != '0) && (hits_q != '1)) ? hits_q + CW'(1) : hits_q;
    end
  end

  always_ff @(posedge CP or negedge CD) begin
    if (!CD) begin
      for (int unsigned k = 1; k <= L; k++)
        for (int unsigned j = 0; j < N; j++) tree_q[k][j] <= '0;
      vld_q  <= '0;
      any_q  <= 1'b0;
      zs_q   <= '0;
      hits_q <= '0;
    end else begin
      for (int unsigned k = 1; k <= L; k++)
        for (int unsigned j = 0; j < N; j++) tree_q[k][j] <= tree_d[k][j];
      vld_q  <= vld_d;
      any_q  <= any_d;
      zs_q   <= zs_d;
      hits_q <= hits_d;
    end
  end

  assign bus.Z    = tree_q[L][0];
  assign bus.ZV   = vld_q[L];
  assign bus.ANY  = any_q;
  assign bus.ZS   = zs_q;
  assign bus.HITS = hits_q;

endmodule
